// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the PC sequencer: FSM encoding,
// flush-counter width, boot/interrupt vector defaults and the idle output vector.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    localparam int CNT_W = 3;

    localparam logic [7:0] DEF_RESET_VEC = 8'h00;
    localparam logic [7:0] DEF_IRQ_VEC   = 8'hF0;

    typedef struct packed {
        logic jump_enable;
        logic flush;
        logic fetch_valid;
        logic irq_ack;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/flush_timer.sv
// Down-counter that times the post-redirect bubble; done marks the last flush cycle.
module flush_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int LOAD_VAL = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LOAD_VAL);
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot vector, branches, interrupt entry/return,
// stall/halt hold and a fixed-length flush bubble after every redirect.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC    = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] IRQ_VEC      = ADDR_W'(DEF_IRQ_VEC),
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              stall_req,
    input  logic              irq_req,
    input  logic              ret_req,
    input  logic              halt_req,
    input  logic              resume,
    output logic              jump_enable,
    output logic [ADDR_W-1:0] jump_address,
    output logic              flush,
    output logic              fetch_valid,
    output logic              irq_ack,
    output logic              in_isr,
    output logic [ADDR_W-1:0] epc,
    output logic [1:0]        state
);

    pc_state_e         state_q, state_d;
    logic              in_isr_q, in_isr_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] jump_addr_d;
    ctrl_t             ctrl;
    logic              timer_load, timer_tick, timer_done;

    flush_timer #(
        .LOAD_VAL (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .tick    (timer_tick),
        .done    (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_BOOT;
            in_isr_q <= 1'b0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            in_isr_q <= in_isr_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        ctrl        = CTRL_IDLE;
        jump_addr_d = pc_in;
        state_d     = state_q;
        in_isr_d    = in_isr_q;
        epc_d       = epc_q;
        timer_load  = 1'b0;
        timer_tick  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                ctrl.jump_enable = 1'b1;
                jump_addr_d      = RESET_VEC;
                state_d          = ST_RUN;
            end

            ST_RUN: begin
                // Masked irq and orphan ret fall through to the lower-priority checks.
                if (halt_req) begin
                    ctrl.jump_enable = 1'b1;
                    state_d          = ST_HALT;
                end else if (irq_req && !in_isr_q) begin
                    ctrl.jump_enable = 1'b1;
                    ctrl.irq_ack     = 1'b1;
                    jump_addr_d      = IRQ_VEC;
                    epc_d            = pc_in;
                    in_isr_d         = 1'b1;
                    timer_load       = 1'b1;
                    state_d          = ST_FLUSH;
                end else if (br_req) begin
                    ctrl.jump_enable = 1'b1;
                    jump_addr_d      = br_target;
                    timer_load       = 1'b1;
                    state_d          = ST_FLUSH;
                end else if (ret_req && in_isr_q) begin
                    ctrl.jump_enable = 1'b1;
                    jump_addr_d      = epc_q;
                    in_isr_d         = 1'b0;
                    timer_load       = 1'b1;
                    state_d          = ST_FLUSH;
                end else if (stall_req) begin
                    ctrl.jump_enable = 1'b1;
                end else begin
                    ctrl.fetch_valid = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Requests seen here come from killed instructions; only stall acts.
                ctrl.flush       = 1'b1;
                ctrl.jump_enable = stall_req;
                timer_tick       = 1'b1;
                if (timer_done) begin
                    state_d = ST_RUN;
                end
            end

            ST_HALT: begin
                ctrl.jump_enable = 1'b1;
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign jump_enable  = ctrl.jump_enable;
    assign jump_address = jump_addr_d;
    assign flush        = ctrl.flush;
    assign fetch_valid  = ctrl.fetch_valid;
    assign irq_ack      = ctrl.irq_ack;
    assign in_isr       = in_isr_q;
    assign epc          = epc_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset/defer
// sequences, then randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] pc_in;
    logic       br_req;
    logic [7:0] br_target;
    logic       stall_req, irq_req, ret_req, halt_req, resume;
    logic       jump_enable;
    logic [7:0] jump_address;
    logic       flush, fetch_valid, irq_ack, in_isr;
    logic [7:0] epc;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .ADDR_W       (8),
        .RESET_VEC    (8'h00),
        .IRQ_VEC      (8'hF0),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_in        (pc_in),
        .br_req       (br_req),
        .br_target    (br_target),
        .stall_req    (stall_req),
        .irq_req      (irq_req),
        .ret_req      (ret_req),
        .halt_req     (halt_req),
        .resume       (resume),
        .jump_enable  (jump_enable),
        .jump_address (jump_address),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .irq_ack      (irq_ack),
        .in_isr       (in_isr),
        .epc          (epc),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        br_req = 0; br_target = 8'h00; stall_req = 0; irq_req = 0;
        ret_req = 0; halt_req = 0; resume = 0;
    endtask

    typedef struct {
        logic [7:0] pc;
        logic       br;
        logic [7:0] tgt;
        logic       stall, irq, ret, halt, res;
        logic       je;
        logic [7:0] ja;
        logic       fl, fv, ack;
        logic [1:0] st;
        logic       isr;
        logic [7:0] epc;
    } vec_t;

    function automatic vec_t v(input logic [7:0] pc, input logic br, input logic [7:0] tgt,
                               input logic stall, input logic irq, input logic ret,
                               input logic halt, input logic res, input logic je,
                               input logic [7:0] ja, input logic fl, input logic fv,
                               input logic ack, input logic [1:0] st, input logic isr,
                               input logic [7:0] ep);
        vec_t r;
        r.pc = pc; r.br = br; r.tgt = tgt; r.stall = stall; r.irq = irq; r.ret = ret;
        r.halt = halt; r.res = res; r.je = je; r.ja = ja; r.fl = fl; r.fv = fv;
        r.ack = ack; r.st = st; r.isr = isr; r.epc = ep;
        return r;
    endfunction

    // Behavioural model: plain flags and a remaining-bubble count.
    bit         m_boot, m_halt, m_isr;
    int         m_left;
    logic [7:0] m_epc;
    logic [7:0] pc;

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_isr = 0; m_left = 0; m_epc = 8'h00;
    endtask

    vec_t tbl[$];

    initial begin
        reset_n = 1'b0;
        pc_in   = 8'h00;
        clear_inputs();

        tbl.push_back(v(8'h00,0,8'h00,0,0,0,0,0, 1,8'h00,0,0,0,2'd0,0,8'h00));
        tbl.push_back(v(8'h00,0,8'h00,0,0,0,0,0, 0,8'h00,0,1,0,2'd1,0,8'h00));
        tbl.push_back(v(8'h10,1,8'h40,0,0,0,0,0, 1,8'h40,0,0,0,2'd1,0,8'h00));
        tbl.push_back(v(8'h40,1,8'h77,0,0,0,0,0, 0,8'h00,1,0,0,2'd2,0,8'h00));
        tbl.push_back(v(8'h40,0,8'h00,0,0,0,0,0, 0,8'h00,1,0,0,2'd2,0,8'h00));
        tbl.push_back(v(8'h40,0,8'h00,0,0,0,0,0, 0,8'h00,0,1,0,2'd1,0,8'h00));
        tbl.push_back(v(8'h22,1,8'h55,0,1,0,0,0, 1,8'hF0,0,0,1,2'd1,0,8'h00));
        tbl.push_back(v(8'hF0,0,8'h00,0,1,0,0,0, 0,8'h00,1,0,0,2'd2,1,8'h22));
        tbl.push_back(v(8'hF0,0,8'h00,1,1,0,0,0, 1,8'hF0,1,0,0,2'd2,1,8'h22));
        tbl.push_back(v(8'hF0,0,8'h00,0,1,0,0,0, 0,8'h00,0,1,0,2'd1,1,8'h22));
        tbl.push_back(v(8'hF1,0,8'h00,0,0,1,0,0, 1,8'h22,0,0,0,2'd1,1,8'h22));
        tbl.push_back(v(8'h22,0,8'h00,0,0,1,0,0, 0,8'h00,1,0,0,2'd2,0,8'h22));
        tbl.push_back(v(8'h22,0,8'h00,0,0,0,0,0, 0,8'h00,1,0,0,2'd2,0,8'h22));
        tbl.push_back(v(8'h22,0,8'h00,0,0,1,0,0, 0,8'h00,0,1,0,2'd1,0,8'h22));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(8'h23,0,8'h00,1,0,0,0,0, 1,8'h23,0,0,0,2'd1,0,8'h22));
        tbl.push_back(v(8'h23,0,8'h00,0,0,0,0,0, 0,8'h00,0,1,0,2'd1,0,8'h22));
        tbl.push_back(v(8'h24,0,8'h00,0,0,0,1,0, 1,8'h24,0,0,0,2'd1,0,8'h22));
        tbl.push_back(v(8'h24,0,8'h00,0,0,0,1,1, 1,8'h24,0,0,0,2'd3,0,8'h22));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(8'h24,0,8'h00,0,0,0,0,0, 1,8'h24,0,0,0,2'd3,0,8'h22));
        tbl.push_back(v(8'h24,0,8'h00,0,0,0,0,1, 1,8'h24,0,0,0,2'd3,0,8'h22));
        tbl.push_back(v(8'h24,0,8'h00,0,0,0,0,0, 0,8'h00,0,1,0,2'd1,0,8'h22));

        // Reset state while reset_n is held low.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", state, 2'd0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_fv", fetch_valid, 1'b0);
        chk("rst_ack", irq_ack, 1'b0);
        chk("rst_isr", in_isr, 1'b0);
        chk("rst_epc", epc, 8'h00);
        chk("rst_je", jump_enable, 1'b1);
        chk("rst_ja", jump_address, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vector table; first entry is the BOOT cycle after release.
        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            pc_in = tbl[i].pc; br_req = tbl[i].br; br_target = tbl[i].tgt;
            stall_req = tbl[i].stall; irq_req = tbl[i].irq; ret_req = tbl[i].ret;
            halt_req = tbl[i].halt; resume = tbl[i].res;
            #1;
            chk($sformatf("tbl%0d_je", i), jump_enable, tbl[i].je);
            if (tbl[i].je) chk($sformatf("tbl%0d_ja", i), jump_address, tbl[i].ja);
            chk($sformatf("tbl%0d_flush", i), flush, tbl[i].fl);
            chk($sformatf("tbl%0d_fv", i), fetch_valid, tbl[i].fv);
            chk($sformatf("tbl%0d_ack", i), irq_ack, tbl[i].ack);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_isr", i), in_isr, tbl[i].isr);
            chk($sformatf("tbl%0d_epc", i), epc, tbl[i].epc);
        end

        // irq raised during FLUSH is deferred to the first RUN cycle.
        @(negedge clk); clear_inputs(); pc_in = 8'h25; br_req = 1; br_target = 8'h60;
        #1; chk("dfr_br_ja", jump_address, 8'h60); chk("dfr_br_je", jump_enable, 1'b1);
        @(negedge clk); clear_inputs(); pc_in = 8'h60; irq_req = 1;
        #1; chk("dfr_f1_state", state, 2'd2); chk("dfr_f1_ack", irq_ack, 1'b0);
        @(negedge clk);
        #1; chk("dfr_f2_state", state, 2'd2); chk("dfr_f2_ack", irq_ack, 1'b0);
        @(negedge clk);
        #1; chk("dfr_run_ack", irq_ack, 1'b1); chk("dfr_run_ja", jump_address, 8'hF0);
        chk("dfr_run_state", state, 2'd1);
        @(negedge clk); clear_inputs(); pc_in = 8'hF0;
        #1; chk("dfr_epc", epc, 8'h60); chk("dfr_isr", in_isr, 1'b1);
        chk("dfr_flush", flush, 1'b1);

        // Asynchronous reset in the middle of FLUSH.
        #2; reset_n = 1'b0;
        #1; chk("mrst_state", state, 2'd0); chk("mrst_flush", flush, 1'b0);
        chk("mrst_isr", in_isr, 1'b0); chk("mrst_epc", epc, 8'h00);
        chk("mrst_je", jump_enable, 1'b1); chk("mrst_ja", jump_address, 8'h00);
        @(negedge clk); reset_n = 1'b1;
        #1; chk("mrst_boot_state", state, 2'd0); chk("mrst_boot_ja", jump_address, 8'h00);
        @(negedge clk);
        #1; chk("mrst_run_state", state, 2'd1); chk("mrst_run_fv", fetch_valid, 1'b1);

        // halt_req raised during FLUSH is taken in RUN; then reset mid-HALT.
        @(negedge clk); pc_in = 8'h01; br_req = 1; br_target = 8'h30;
        @(negedge clk); clear_inputs(); pc_in = 8'h30; halt_req = 1;
        #1; chk("hf_f1_state", state, 2'd2);
        @(negedge clk);
        #1; chk("hf_f2_state", state, 2'd2);
        @(negedge clk);
        #1; chk("hf_run_state", state, 2'd1); chk("hf_run_je", jump_enable, 1'b1);
        chk("hf_run_ja", jump_address, 8'h30);
        @(negedge clk);
        #1; chk("hf_halt_state", state, 2'd3);
        #2; reset_n = 1'b0;
        #1; chk("hrst_state", state, 2'd0); chk("hrst_fv", fetch_valid, 1'b0);
        @(negedge clk); clear_inputs(); reset_n = 1'b1;

        // Randomized traffic against the model.
        model_reset();
        pc = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            logic       e_je, e_fl, e_fv, e_ack;
            logic [7:0] e_ja;
            logic [1:0] e_st;
            bit         n_boot, n_halt, n_isr;
            int         n_left;
            logic [7:0] n_epc;
            if (n != 0) @(negedge clk);
            br_req    = ($urandom_range(0, 9) == 0);
            br_target = 8'($urandom_range(0, 255));
            stall_req = ($urandom_range(0, 6) == 0);
            irq_req   = ($urandom_range(0, 9) == 0);
            ret_req   = ($urandom_range(0, 7) == 0);
            halt_req  = ($urandom_range(0, 24) == 0);
            resume    = ($urandom_range(0, 3) == 0);
            pc_in     = pc;
            #1;
            e_je = 0; e_ja = pc; e_fl = 0; e_fv = 0; e_ack = 0;
            n_boot = m_boot; n_halt = m_halt; n_isr = m_isr; n_left = m_left; n_epc = m_epc;
            e_st = m_boot ? 2'd0 : m_halt ? 2'd3 : (m_left > 0) ? 2'd2 : 2'd1;
            if (m_boot) begin
                e_je = 1; e_ja = 8'h00; n_boot = 0;
            end else if (m_halt) begin
                e_je = 1;
                if (resume && !halt_req) n_halt = 0;
            end else if (m_left > 0) begin
                e_fl = 1; e_je = stall_req; n_left = m_left - 1;
            end else if (halt_req) begin
                e_je = 1; n_halt = 1;
            end else if (irq_req && !m_isr) begin
                e_je = 1; e_ja = 8'hF0; e_ack = 1; n_epc = pc; n_isr = 1; n_left = FC;
            end else if (br_req) begin
                e_je = 1; e_ja = br_target; n_left = FC;
            end else if (ret_req && m_isr) begin
                e_je = 1; e_ja = m_epc; n_isr = 0; n_left = FC;
            end else if (stall_req) begin
                e_je = 1;
            end else begin
                e_fv = 1;
            end
            chk("rnd_je", jump_enable, e_je);
            if (e_je) chk("rnd_ja", jump_address, e_ja);
            chk("rnd_flush", flush, e_fl);
            chk("rnd_fv", fetch_valid, e_fv);
            chk("rnd_ack", irq_ack, e_ack);
            chk("rnd_state", state, e_st);
            chk("rnd_isr", in_isr, m_isr);
            chk("rnd_epc", epc, m_epc);
            m_boot = n_boot; m_halt = n_halt; m_isr = n_isr; m_left = n_left; m_epc = n_epc;
            pc = e_je ? e_ja : pc + 8'h01;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, width of all PC addresses.
REQ-002 Parameter RESET_VEC, default 8'h00, boot address.
REQ-003 Parameter IRQ_VEC, default 8'hF0, interrupt handler address.
REQ-004 Parameter FLUSH_CYCLES, default 2, range 1-7, bubble count after any redirect.
REQ-005 The block SHALL have one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-006 Ports SHALL be:
- clk, in, 1, clock.
- reset_n, in, 1, async active-low reset.
- pc_in, in, ADDR_W, current program_counter pc_out.
- br_req, in, 1, taken-branch request.
- br_target, in, ADDR_W, branch target.
- stall_req, in, 1, hold PC this cycle.
- irq_req, in, 1, level interrupt request.
- ret_req, in, 1, return from interrupt.
- halt_req, in, 1, enter HALT.
- resume, in, 1, leave HALT.
- jump_enable, out, 1, drives program_counter jump_enable.
- jump_address, out, ADDR_W, drives program_counter jump_address.
- flush, out, 1, kill in-flight fetch/decode.
- fetch_valid, out, 1, fetched instruction valid.
- irq_ack, out, 1, one-cycle interrupt accept pulse.
- in_isr, out, 1, interrupt handler active.
- epc, out, ADDR_W, saved return address.
- state, out, 2, FSM state.

Function
REQ-007 FSM states SHALL be BOOT=0, RUN=1, FLUSH=2, HALT=3.
REQ-008 jump_enable and jump_address SHALL be combinational from state and inputs, so a redirect decided in cycle N loads the PC at edge N+1 (zero added latency).
REQ-009 BOOT SHALL drive jump_enable=1 and jump_address=RESET_VEC for one cycle, then go to RUN.
REQ-010 In RUN, priority SHALL be halt_req > irq > br_req > ret_req > stall_req > sequential.
REQ-011 halt_req SHALL hold (jump_enable=1, jump_address=pc_in) and go to HALT.
REQ-012 irq_req && !in_isr SHALL:
- latch epc=pc_in;
- drive jump to IRQ_VEC;
- pulse irq_ack for that cycle;
- set in_isr;
- go to FLUSH.
REQ-013 br_req SHALL jump to br_target and go to FLUSH.
REQ-014 ret_req && in_isr SHALL jump to epc, clear in_isr, and go to FLUSH; ret_req with !in_isr SHALL be ignored.
REQ-015 stall_req alone SHALL hold the PC (jump_enable=1, jump_address=pc_in) and force fetch_valid=0, with no state change.
REQ-016 With no request, jump_enable SHALL be 0 and fetch_valid 1.
REQ-017 FLUSH SHALL last exactly FLUSH_CYCLES cycles, counted by a 3-bit down-counter.
- flush=1 and fetch_valid=0 throughout.
- br_req and ret_req SHALL be ignored; they come from killed instructions.
- stall_req SHALL hold the PC without extending the count.
REQ-018 irq_req arriving in FLUSH SHALL be deferred, not dropped; it is taken in the first RUN cycle if still asserted.
REQ-019 halt_req arriving in FLUSH SHALL be taken in the first RUN cycle if still asserted.
REQ-020 HALT SHALL hold the PC every cycle with fetch_valid=0. resume SHALL return to RUN; halt_req and resume high together SHALL stay in HALT.
REQ-021 irq_req while in_isr SHALL be masked with no ack; nesting is unsupported.
REQ-022 flush SHALL be 0 in BOOT, RUN and HALT.

Reset
REQ-023 reset_n low SHALL asynchronously set:
- state=BOOT, counter=0, in_isr=0, epc=0;
- irq_ack=0, flush=0, fetch_valid=0.
REQ-024 jump_enable SHALL be 1 with jump_address=RESET_VEC while in BOOT.
REQ-025 Reset asserted mid-FLUSH or mid-HALT SHALL discard all pending state.

Structure
REQ-026 State encodings and default vectors SHALL live in shared package cpu_ctrl_pkg.
REQ-027 The flush counter SHALL be sub-module flush_timer (load, tick, done).

Verification
REQ-028 Reset release SHALL give jump_enable=1, jump_address=8'h00 for one cycle, then RUN with fetch_valid=1.
REQ-029 br_req=1, br_target=8'h40 at pc_in=8'h10 SHALL give:
- jump to 8'h40 in the same cycle;
- flush=1 for exactly 2 cycles;
- a second br_req during FLUSH ignored.
REQ-030 irq_req at pc_in=8'h22 SHALL give:
- irq_ack pulse, epc=8'h22, jump to 8'hF0, in_isr=1.
- A later ret_req SHALL jump to 8'h22 and clear in_isr.
REQ-031 irq_req and br_req high together SHALL take the irq: jump to 8'hF0; the branch is lost.
REQ-032 stall_req for 3 cycles SHALL hold pc_in constant and keep fetch_valid=0 for those cycles. halt_req, then resume 5 cycles later, SHALL freeze the PC and then resume sequential fetch.
REQ-033 reset_n pulsed low mid-FLUSH SHALL give immediate BOOT with flush=0, then a jump to 8'h00.
